// File: rtl/edge_engine_multi.sv
// edge_engine_multi: 3x3 edge detector on a raster grayscale stream.
// It builds the 3x3 window from two internal line buffers and applies a kernel chosen
// at run time (Sobel, Prewitt or Scharr). It produces a saturated L1 magnitude, a
// thresholded edge bit and an edge count for each frame.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   frame_start         1-cycle start-of-frame pulse; also latches kernel_mode and threshold
//   pix_valid, pix_in   raster-order pixel input; gaps between pixels are allowed
//   kernel_mode         00 Sobel, 01 Prewitt, 10 Scharr, 11 Sobel
//   threshold           edge threshold, compared with out_mag (>=)
//   out_valid/mag/edge  one result per accepted pixel, 3 cycles after the pixel
//   frame_done          1-cycle pulse the cycle after the last result of a complete frame
//   edge_count          edge count of the last completed frame
//   sync_err            sticky protocol-error flag
module edge_engine_multi #(
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH   = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   pix_valid,
  input  logic [PIXEL_WIDTH-1:0] pix_in,
  input  logic [1:0]             kernel_mode,
  input  logic [PIXEL_WIDTH-1:0] threshold,
  output logic                   out_valid,
  output logic [PIXEL_WIDTH-1:0] out_mag,
  output logic                   out_edge,
  output logic                   frame_done,
  output logic [CNT_WIDTH-1:0]   edge_count,
  output logic                   sync_err
);

  localparam int unsigned PW = PIXEL_WIDTH;
  localparam int unsigned GW = PW + 5;
  localparam int unsigned SW = PW + 6;
  localparam int unsigned XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned YW = $clog2(IMG_HEIGHT + 1);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [SW-1:0] MAG_MAX = SW'({PW{1'b1}});
  localparam logic [1:0]    MODE_PREWITT = 2'b01;
  localparam logic [1:0]    MODE_SCHARR  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       col_q, col_d, col_base_c;
  logic [YW-1:0]       row_q, row_d, row_base_c;
  logic [1:0]          mode_q, mode_use_c;
  logic [PW-1:0]       thr_q, thr_use_c;
  logic                accept_c, last_pix_c, border_c, done_fire_c;

  logic [PW-1:0]       lb0_mem [IMG_WIDTH];
  logic [PW-1:0]       lb1_mem [IMG_WIDTH];
  logic [PW-1:0]       lb0_rd_c, lb1_rd_c;

  // Stage 1: window, index 2 is the newest column
  logic [2:0][PW-1:0]  win_top_q, win_mid_q, win_bot_q;
  logic                s1_valid_q, s1_border_q, s1_last_q;
  logic [1:0]          s1_mode_q;
  logic [PW-1:0]       s1_thr_q;

  // Stage 2: gradients
  logic signed [GW-1:0] gx_q, gy_q, gx_c, gy_c;
  logic signed [GW-1:0] wa_c, wb_c;
  logic signed [GW-1:0] dxt_c, dxm_c, dxb_c, dyl_c, dyc_c, dyr_c;
  logic                 s2_valid_q, s2_border_q, s2_last_q, s2_cnt_q;
  logic [1:0]           s2_mode_q;
  logic [PW-1:0]        s2_thr_q;

  // Stage 3: magnitude and threshold
  logic [GW-1:0]        abs_x_c, abs_y_c;
  logic [SW-1:0]        sum_c, shr_c;
  logic [PW-1:0]        mag_c;
  logic                 edge_c;
  logic                 out_valid_q, out_edge_q, out_last_q, frame_done_q, sync_err_q;
  logic [PW-1:0]        out_mag_q;
  logic [CNT_WIDTH-1:0] edge_acc_q, edge_count_q;

  function automatic logic signed [GW-1:0] sx(input logic [PW-1:0] p);
    return $signed(GW'(p));
  endfunction

  // Input acceptance, raster position and per-frame settings (frame_start takes effect at once)
  always_comb begin
    col_base_c = frame_start ? '0 : col_q;
    row_base_c = frame_start ? '0 : row_q;
    mode_use_c = frame_start ? kernel_mode : mode_q;
    thr_use_c  = frame_start ? threshold : thr_q;
    accept_c   = pix_valid && (frame_start || (state_q == ACTIVE));
    last_pix_c = (col_base_c == X_LAST) && (row_base_c == Y_LAST);
    border_c   = (row_base_c < YW'(2)) || (col_base_c < XW'(2));
    lb0_rd_c   = lb0_mem[col_base_c];
    lb1_rd_c   = lb1_mem[col_base_c];
    col_d      = col_base_c;
    row_d      = row_base_c;
    if (accept_c) begin
      if (col_base_c == X_LAST) begin
        col_d = '0;
        row_d = row_base_c + YW'(1);
      end else begin
        col_d = col_base_c + XW'(1);
      end
    end
  end

  // Frame FSM next state
  always_comb begin
    done_fire_c = (state_q == DONE) && out_last_q && !frame_start;
    state_d     = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      DONE: begin
        if (frame_start)      state_d = ACTIVE;
        else if (done_fire_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept_c && last_pix_c) state_d = DONE;
  end

  // Line buffers: lb0 holds the previous line, lb1 the one before it
  always_ff @(posedge clk) begin
    if (accept_c) begin
      lb1_mem[col_base_c] <= lb0_rd_c;
      lb0_mem[col_base_c] <= pix_in;
    end
  end

  // Kernel weights and column/row differences
  always_comb begin
    case (s1_mode_q)
      MODE_PREWITT: begin wa_c = GW'(1); wb_c = GW'(1);  end
      MODE_SCHARR:  begin wa_c = GW'(3); wb_c = GW'(10); end
      default:      begin wa_c = GW'(1); wb_c = GW'(2);  end
    endcase
    dxt_c = sx(win_top_q[2]) - sx(win_top_q[0]);
    dxm_c = sx(win_mid_q[2]) - sx(win_mid_q[0]);
    dxb_c = sx(win_bot_q[2]) - sx(win_bot_q[0]);
    dyl_c = sx(win_bot_q[0]) - sx(win_top_q[0]);
    dyc_c = sx(win_bot_q[1]) - sx(win_top_q[1]);
    dyr_c = sx(win_bot_q[2]) - sx(win_top_q[2]);
    gx_c  = wa_c * dxt_c + wb_c * dxm_c + wa_c * dxb_c;
    gy_c  = wa_c * dyl_c + wb_c * dyc_c + wa_c * dyr_c;
  end

  // L1 magnitude, kernel normalisation, saturation and threshold
  always_comb begin
    abs_x_c = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    abs_y_c = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    sum_c   = SW'(abs_x_c) + SW'(abs_y_c);
    case (s2_mode_q)
      MODE_PREWITT: shr_c = sum_c >> 2;
      MODE_SCHARR:  shr_c = sum_c >> 5;
      default:      shr_c = sum_c >> 3;
    endcase
    mag_c  = (shr_c > MAG_MAX) ? {PW{1'b1}} : PW'(shr_c);
    if (s2_border_q) mag_c = '0;
    edge_c = !s2_border_q && (mag_c >= s2_thr_q);
  end

  // Control, pipeline and output registers. A frame_start kills the count/last tags of
  // results still in flight so an aborted frame never reaches frame_done or edge_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= '0;
      thr_q        <= '0;
      win_top_q    <= '0;
      win_mid_q    <= '0;
      win_bot_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_border_q  <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_mode_q    <= '0;
      s1_thr_q     <= '0;
      gx_q         <= '0;
      gy_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_border_q  <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_cnt_q     <= 1'b0;
      s2_mode_q    <= '0;
      s2_thr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_mag_q    <= '0;
      out_edge_q   <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      edge_acc_q   <= '0;
      edge_count_q <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_use_c;
      thr_q   <= thr_use_c;

      if (accept_c) begin
        win_top_q <= {lb1_rd_c, win_top_q[2:1]};
        win_mid_q <= {lb0_rd_c, win_mid_q[2:1]};
        win_bot_q <= {pix_in,   win_bot_q[2:1]};
      end
      s1_valid_q  <= accept_c;
      s1_border_q <= border_c;
      s1_last_q   <= accept_c && last_pix_c;
      s1_mode_q   <= mode_use_c;
      s1_thr_q    <= thr_use_c;

      gx_q        <= gx_c;
      gy_q        <= gy_c;
      s2_valid_q  <= s1_valid_q;
      s2_border_q <= s1_border_q;
      s2_last_q   <= s1_last_q && !frame_start;
      s2_cnt_q    <= s1_valid_q && !frame_start;
      s2_mode_q   <= s1_mode_q;
      s2_thr_q    <= s1_thr_q;

      out_valid_q <= s2_valid_q;
      out_mag_q   <= s2_valid_q ? mag_c : '0;
      out_edge_q  <= s2_valid_q && edge_c;
      out_last_q  <= s2_last_q && !frame_start;

      if (frame_start) begin
        edge_acc_q <= '0;
      end else if (s2_cnt_q && edge_c && (edge_acc_q != '1)) begin
        edge_acc_q <= edge_acc_q + CNT_WIDTH'(1);
      end

      frame_done_q <= done_fire_c;
      if (done_fire_c) edge_count_q <= edge_acc_q;

      if ((frame_start && (state_q != IDLE)) ||
          (pix_valid && !frame_start && (state_q != ACTIVE))) begin
        sync_err_q <= 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_mag    = out_mag_q;
  assign out_edge   = out_edge_q;
  assign frame_done = frame_done_q;
  assign edge_count = edge_count_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_edge_engine_multi.sv
// Testbench for edge_engine_multi on an 8x4 image: a scoreboard queue is filled with
// expected results as pixels are driven and drained by a monitor on the falling edge.
module tb_edge_engine_multi;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk, rst_n, frame_start, pix_valid;
  logic [7:0]  pix_in, threshold;
  logic [1:0]  kernel_mode;
  logic        out_valid, out_edge, frame_done, sync_err;
  logic [7:0]  out_mag;
  logic [19:0] edge_count;

  typedef struct {
    int mag;
    int edg;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   img [H][W];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ov_cnt = 0;
  int   done_cnt = 0;
  int   last_ov_cyc = -10;

  edge_engine_multi #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .CNT_WIDTH(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_in(pix_in), .kernel_mode(kernel_mode), .threshold(threshold),
    .out_valid(out_valid), .out_mag(out_mag), .out_edge(out_edge),
    .frame_done(frame_done), .edge_count(edge_count), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: result for input (r,c) is the kernel applied to the window centred at (r-1,c-1)
  function automatic int model_mag(input int r, input int c, input int mode);
    int a, b, sh, gx, gy, s;
    int w[3];
    if (r < 2 || c < 2) return 0;
    case (mode)
      1:       begin a = 1; b = 1;  sh = 2; end
      2:       begin a = 3; b = 10; sh = 5; end
      default: begin a = 1; b = 2;  sh = 3; end
    endcase
    w[0] = a; w[1] = b; w[2] = a;
    gx = 0; gy = 0;
    for (int k = 0; k < 3; k++) begin
      gx += w[k] * (img[r-2+k][c] - img[r-2+k][c-2]);
      gy += w[k] * (img[r][c-2+k] - img[r-2][c-2+k]);
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = (gx + gy) >> sh;
    if (s > 255) s = 255;
    return s;
  endfunction

  // Monitor: frame_done timing and scoreboard comparison of every result
  initial forever begin
    @(negedge clk);
    if (rst_n && frame_done) begin
      done_cnt++;
      checks++;
      if (cyc != last_ov_cyc + 1) begin
        errors++;
        $display("FAIL frame_done_timing: at cycle %0d, required cycle %0d", cyc, last_ov_cyc + 1);
      end
    end
    if (rst_n && out_valid) begin
      exp_t e;
      ov_cnt++;
      last_ov_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: out_valid=1 mag=%0d at cycle %0d, required no result", out_mag, cyc);
      end else begin
        e = exp_q.pop_front();
        if (int'(out_mag) != e.mag || int'(out_edge) != e.edg || cyc != e.cyc) begin
          errors++;
          $display("FAIL result: mag=%0d edge=%0d cycle=%0d, required mag=%0d edge=%0d cycle=%0d",
                   out_mag, out_edge, cyc, e.mag, e.edg, e.cyc);
        end
      end
    end
  end

  task automatic set_uniform(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic set_step();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 255 : 0;
  endtask

  // Drive npix pixels of img (frame_start with the first); at pixel chg_at the mode/threshold
  // inputs are changed, which the design must ignore for this frame.
  task automatic drive_frame(input int mode, input int thr, input int gap_pct, input int npix,
                             input int chg_at);
    for (int i = 0; i < npix; i++) begin
      int r, c, ng;
      exp_t e;
      r = i / W;
      c = i % W;
      ng = 0;
      if (i > 0) begin
        while ($urandom_range(99) < gap_pct && ng < 4) begin
          @(negedge clk);
          pix_valid = 1'b0;
          frame_start = 1'b0;
          ng++;
        end
      end
      @(negedge clk);
      frame_start = (i == 0);
      pix_valid = 1'b1;
      pix_in = 8'(img[r][c]);
      if (i == 0) begin
        kernel_mode = 2'(mode);
        threshold = 8'(thr);
      end
      if (i == chg_at) begin
        kernel_mode = 2'b01;
        threshold = 8'd50;
      end
      e.mag = model_mag(r, c, mode);
      e.edg = (r >= 2 && c >= 2 && e.mag >= thr) ? 1 : 0;
      e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    @(negedge clk);
    frame_start = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && i >= 6) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_mag !== 8'd0 || out_edge !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b mag=%0d edge=%b, required 0 0 0", out_valid, out_mag, out_edge);
    end
    checks++;
    if (frame_done !== 1'b0 || edge_count !== 20'd0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: done=%b count=%0d err=%b, required 0 0 0", frame_done, edge_count, sync_err);
    end
  endtask

  task automatic test_uniform();
    int d0, v0;
    bit ok;
    set_uniform(100);
    d0 = done_cnt;
    v0 = ov_cnt;
    drive_frame(0, 10, 0, W * H, -1);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL uniform_drain: %0d results missing, required 0", exp_q.size()); end
    checks++;
    if (ov_cnt - v0 != W * H) begin errors++; $display("FAIL uniform_results: %0d, required %0d", ov_cnt - v0, W * H); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL uniform_done: %0d pulses, required 1", done_cnt - d0); end
    checks++;
    if (int'(edge_count) != 0) begin errors++; $display("FAIL uniform_count: %0d, required 0", edge_count); end
  endtask

  task automatic test_step();
    bit ok;
    set_step();
    drive_frame(0, 100, 0, W * H, -1);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL step_drain: %0d results missing, required 0", exp_q.size()); end
    checks++;
    if (int'(edge_count) != 4) begin errors++; $display("FAIL step_count: %0d, required 4", edge_count); end
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL step_sync_err: %b, required 0", sync_err); end
  endtask

  task automatic test_kernels();
    int modes[3] = '{1, 2, 3};
    int thrs[3]  = '{150, 127, 128};
    int cnts[3]  = '{4, 4, 0};
    bit ok;
    set_step();
    for (int k = 0; k < 3; k++) begin
      drive_frame(modes[k], thrs[k], 0, W * H, -1);
      drain(ok);
      checks++;
      if (!ok || int'(edge_count) != cnts[k]) begin
        errors++;
        $display("FAIL kernel_mode%0d_count: %0d (drained=%0d), required %0d", modes[k], edge_count, ok, cnts[k]);
      end
    end
  endtask

  task automatic test_mode_change();
    bit ok;
    set_step();
    drive_frame(0, 150, 0, W * H, 5);
    drain(ok);
    checks++;
    if (!ok || int'(edge_count) != 0) begin
      errors++;
      $display("FAIL midframe_change_count: %0d (drained=%0d), required 0", edge_count, ok);
    end
    drive_frame(1, 150, 0, W * H, -1);
    drain(ok);
    checks++;
    if (!ok || int'(edge_count) != 4) begin
      errors++;
      $display("FAIL next_frame_prewitt_count: %0d (drained=%0d), required 4", edge_count, ok);
    end
  endtask

  task automatic test_abort();
    int d0;
    bit ok;
    set_step();
    d0 = done_cnt;
    drive_frame(0, 100, 0, 10, -1);
    drive_frame(1, 200, 0, W * H, -1);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_drain: %0d results missing, required 0", exp_q.size()); end
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL abort_sync_err: %b, required 1", sync_err); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_done: %0d pulses, required 1", done_cnt - d0); end
    checks++;
    if (int'(edge_count) != 0) begin errors++; $display("FAIL abort_count: %0d, required 0", edge_count); end
  endtask

  task automatic test_idle_gaps_reset();
    int d0, v0;
    bit ok;
    pulse_reset();
    @(negedge clk);
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_clears_sync_err: %b, required 0", sync_err); end
    v0 = ov_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_in = 8'(40 * i);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL idle_pixel_sync_err: %b, required 1", sync_err); end
    checks++;
    if (ov_cnt != v0) begin errors++; $display("FAIL idle_pixel_results: %0d, required 0", ov_cnt - v0); end

    set_step();
    d0 = done_cnt;
    v0 = ov_cnt;
    drive_frame(0, 100, 30, W * H, -1);
    drain(ok);
    checks++;
    if (!ok || ov_cnt - v0 != W * H) begin
      errors++;
      $display("FAIL gapped_results: %0d (drained=%0d), required %0d", ov_cnt - v0, ok, W * H);
    end
    checks++;
    if (done_cnt - d0 != 1 || int'(edge_count) != 4) begin
      errors++;
      $display("FAIL gapped_frame: done=%0d count=%0d, required done=1 count=4", done_cnt - d0, edge_count);
    end

    drive_frame(0, 100, 0, 12, -1);
    pulse_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_mag !== 8'd0 || frame_done !== 1'b0 ||
        edge_count !== 20'd0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: valid=%b mag=%0d done=%b count=%0d err=%b, required all 0",
               out_valid, out_mag, frame_done, edge_count, sync_err);
    end
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in = 8'd9;
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL post_reset_idle: sync_err=%b, required 1", sync_err); end

    d0 = done_cnt;
    drive_frame(0, 100, 0, W * H, -1);
    drain(ok);
    checks++;
    if (!ok || done_cnt - d0 != 1 || int'(edge_count) != 4) begin
      errors++;
      $display("FAIL post_reset_frame: done=%0d count=%0d drained=%0d, required done=1 count=4",
               done_cnt - d0, edge_count, ok);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    pix_in = '0;
    kernel_mode = '0;
    threshold = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_uniform();
    test_step();
    test_kernels();
    test_mode_change();
    test_abort();
    test_idle_gaps_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
